// File: rtl/seven_segment_mux.sv
// Scans NUM_DIGITS common-anode digits over one shared active-low segment bus.
// Each slot starts with a blanking interval. Define LEADING_ZERO_BLANK_EN to suppress leading zeros.
module seven_segment_mux #(
    parameter int NUM_DIGITS   = 2,
    parameter int REFRESH_DIV  = 20000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);
    // state | meaning
    // BLANK | all anodes off, slot settling time
    // SHOW  | selected anode on with the latched digit value
    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [IW-1:0]         r_idx, w_idx_nxt;
    logic [3:0]            r_val, w_val_nxt;
    logic                  r_en, w_en_nxt;
    logic [6:0]            r_seg, w_seg_nxt;
    logic [NUM_DIGITS-1:0] r_anode, w_anode_nxt;
    logic                  r_frame_done, w_frame_done_nxt;
    logic                  w_wrap, w_latch, w_lz, w_sel_en;
    logic [3:0]            w_sel_val;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        w_wrap    = (r_cnt == CNT_MAX);
        w_cnt_nxt = w_wrap ? '0 : r_cnt + CW'(1);
        w_idx_nxt = r_idx;
        if (w_wrap)
            w_idx_nxt = (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
        w_latch = (w_cnt_nxt == CNT_SHOW);

        w_sel_val = 4'h0;
        w_sel_en  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_sel_val = digits[4*i +: 4];
                w_sel_en  = digit_en[i];
            end
        end

        w_lz = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        // Blank only when this digit and every more significant one are zero.
        w_lz = (r_idx != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IW'(i) >= r_idx) && (digits[4*i +: 4] != 4'h0))
                w_lz = 1'b0;
        end
`endif

        w_state_nxt = r_state;
        w_val_nxt   = r_val;
        w_en_nxt    = r_en;
        if (w_wrap) begin
            w_state_nxt = ST_BLANK;
        end else if (w_latch) begin
            w_state_nxt = ST_SHOW;
            w_val_nxt   = w_sel_val;
            w_en_nxt    = w_sel_en & ~w_lz;
        end

        // Outputs are decoded from next-state values so the registers carry no extra lag.
        w_seg_nxt   = 7'h7F;
        w_anode_nxt = '1;
        if ((w_state_nxt == ST_SHOW) && w_en_nxt) begin
            w_seg_nxt = hex_to_seg(w_val_nxt);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_idx_nxt == IW'(i))
                    w_anode_nxt[i] = 1'b0;
            end
        end
        w_frame_done_nxt = w_wrap && (r_idx == IDX_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_val        <= 4'h0;
            r_en         <= 1'b0;
            r_seg        <= 7'h7F;
            r_anode      <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_val        <= w_val_nxt;
            r_en         <= w_en_nxt;
            r_seg        <= w_seg_nxt;
            r_anode      <= w_anode_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign seg        = r_seg;
    assign anode      = r_anode;
    assign frame_done = r_frame_done;

endmodule
